// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_adder_ctrl_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Bit counter must hold 0..width without wrapping.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// One-bit full adder composed of two half adders and an OR of their carries.
module full_adder_ha (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic ha0_s;
  logic ha0_c;
  logic ha1_c;

  // First half adder on the operand bits, second folds in the carry.
  always_comb begin
    ha0_s = a ^ b;
    ha0_c = a & b;
    s     = ha0_s ^ ci;
    ha1_c = ha0_s & ci;
    co    = ha0_c | ha1_c;
  end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: {cout,s} = a + b + cin, one bit per clock, LSB first.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  localparam int unsigned     CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             load_c;
  logic             step_c;
  logic             last_c;
  logic             sum_bit;
  logic             carry_bit;

  full_adder_ha u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (sum_bit),
    .co (carry_bit)
  );

  // Next-state and datapath control decode.
  always_comb begin
    state_nxt = state;
    load_c    = 1'b0;
    step_c    = 1'b0;
    last_c    = (cnt == LAST);
    case (state)
      IDLE: begin
        if (start) begin
          load_c    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step_c = 1'b1;
        if (last_c) state_nxt = FIN;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register with status flags registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == RUN);
      done  <= (state_nxt == FIN);
    end
  end

  // Operand capture, serial shift, carry and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      s     <= '0;
      cout  <= 1'b0;
    end else if (load_c) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (step_c) begin
      a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
      s     <= {sum_bit, s[WIDTH-1:1]};
      carry <= carry_bit;
      cnt   <= cnt + CW'(1);
      if (last_c) cout <= carry_bit;
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH=8 and WIDTH=16.
module tb_serial_adder_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start8, cin8, busy8, done8, cout8;
  logic [7:0]  a8, b8, s8;
  logic        start16, cin16, busy16, done16, cout16;
  logic [15:0] a16, b16, s16;

  int vectors;
  int miscompares;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .s(s8), .cout(cout8)
  );

  serial_adder_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .s(s16), .cout(cout16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1);
  end

  task automatic set_in(input bit w16, input logic st, input logic [31:0] av,
                        input logic [31:0] bv, input logic cv);
    if (w16) begin
      start16 = st; a16 = av[15:0]; b16 = bv[15:0]; cin16 = cv;
    end else begin
      start8 = st; a8 = av[7:0]; b8 = bv[7:0]; cin8 = cv;
    end
  endtask

  function automatic logic [32:0] result_of(input bit w16);
    return w16 ? {16'b0, cout16, s16} : {24'b0, cout8, s8};
  endfunction

  function automatic logic busy_of(input bit w16);
    return w16 ? busy16 : busy8;
  endfunction

  function automatic logic done_of(input bit w16);
    return w16 ? done16 : done8;
  endfunction

  // Reference: plain arithmetic sum truncated to the operand width plus carry.
  function automatic logic [32:0] ref_sum(input bit w16, input logic [31:0] av,
                                          input logic [31:0] bv, input logic cv);
    logic [32:0] mask;
    mask = w16 ? 33'h0_0000_FFFF : 33'h0_0000_00FF;
    return (33'(av) & mask) + (33'(bv) & mask) + 33'(cv);
  endfunction

  // Pulse start for one cycle, then watch busy/done until done or timeout.
  task automatic do_op(input bit w16, input logic [31:0] av, input logic [31:0] bv,
                       input logic cv, input bit noisy, output logic [32:0] res,
                       output int busy_n, output int lat, output bit both);
    busy_n = 0; lat = 0; both = 1'b0; res = '0;
    @(negedge clk); set_in(w16, 1'b1, av, bv, cv);
    @(negedge clk); set_in(w16, 1'b0, av, bv, cv);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (busy_of(w16)) busy_n++;
      if (busy_of(w16) && done_of(w16)) both = 1'b1;
      if (done_of(w16)) begin
        lat = cyc;
        res = result_of(w16);
        break;
      end
      if (noisy) set_in(w16, 1'($urandom_range(0, 1)), $urandom, $urandom,
                        1'($urandom_range(0, 1)));
    end
    set_in(w16, 1'b0, av, bv, cv);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 0, 0, 1'b0);
    set_in(1'b1, 1'b0, 0, 0, 1'b0);
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy8, done8, cout8, s8} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset8: got busy/done/cout/s=%b, want all zero", {busy8, done8, cout8, s8});
    end
    vectors++;
    if ({busy16, done16, cout16, s16} !== 19'd0) begin
      miscompares++;
      $display("FAIL reset16: got busy/done/cout/s=%b, want all zero", {busy16, done16, cout16, s16});
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({busy8, done8, cout8, s8} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_release: got %b after release, want all zero", {busy8, done8, cout8, s8});
    end
  endtask

  task automatic test_basic;
    logic [32:0] res;
    int busy_n, lat;
    bit both;
    do_op(1'b0, 32'h5A, 32'h3C, 1'b0, 1'b0, res, busy_n, lat, both);
    vectors++;
    if (res !== 33'h096) begin
      miscompares++;
      $display("FAIL basic_sum: got %h, want 096", res);
    end
    vectors++;
    if (busy_n !== 8) begin
      miscompares++;
      $display("FAIL basic_busy: got %0d busy cycles, want 8", busy_n);
    end
    vectors++;
    if (lat !== 9) begin
      miscompares++;
      $display("FAIL basic_latency: got done at cycle %0d, want 9", lat);
    end
    vectors++;
    if (both !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_exclusive: busy and done both high, want never");
    end
  endtask

  task automatic test_overflow;
    logic [32:0] res;
    int busy_n, lat;
    bit both;
    do_op(1'b0, 32'hFF, 32'h01, 1'b0, 1'b0, res, busy_n, lat, both);
    vectors++;
    if (res !== 33'h100) begin
      miscompares++;
      $display("FAIL overflow_ff_01: got %h, want 100", res);
    end
    do_op(1'b0, 32'hFF, 32'hFF, 1'b1, 1'b0, res, busy_n, lat, both);
    vectors++;
    if (res !== 33'h1FF) begin
      miscompares++;
      $display("FAIL overflow_ff_ff_1: got %h, want 1ff", res);
    end
  endtask

  task automatic test_back_to_back;
    int done_at[$];
    @(negedge clk); set_in(1'b0, 1'b1, 32'h01, 32'h02, 1'b0);
    for (int cyc = 1; cyc <= 32; cyc++) begin
      @(negedge clk);
      if (done8) begin
        done_at.push_back(cyc);
        vectors++;
        if ({cout8, s8} !== 9'h003) begin
          miscompares++;
          $display("FAIL b2b_sum: got %h at cycle %0d, want 003", {cout8, s8}, cyc);
        end
      end
    end
    set_in(1'b0, 1'b0, 32'h01, 32'h02, 1'b0);
    vectors++;
    if (done_at.size() !== 3) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d done pulses, want 3", done_at.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (done_at[i] !== 9 + 10 * i) begin
          miscompares++;
          $display("FAIL b2b_spacing: pulse %0d at cycle %0d, want %0d", i, done_at[i], 9 + 10 * i);
        end
      end
    end
    repeat (15) @(negedge clk);
  endtask

  task automatic test_operand_change;
    logic [32:0] res;
    int lat;
    res = '0; lat = 0;
    @(negedge clk); set_in(1'b0, 1'b1, 32'h10, 32'h20, 1'b0);
    @(negedge clk); set_in(1'b0, 1'b0, 32'h10, 32'h20, 1'b0);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (cyc == 3) set_in(1'b0, 1'b0, 32'hAA, 32'h55, 1'b1);
      if (done8) begin
        lat = cyc;
        res = result_of(1'b0);
        break;
      end
    end
    vectors++;
    if (res !== 33'h030 || lat !== 9) begin
      miscompares++;
      $display("FAIL operand_change: got %h at cycle %0d, want 030 at cycle 9", res, lat);
    end
  endtask

  task automatic test_reset_mid_run;
    logic [32:0] res;
    int busy_n, lat, dones;
    bit both;
    dones = 0;
    @(negedge clk); set_in(1'b0, 1'b1, 32'h77, 32'h33, 1'b1);
    @(negedge clk); set_in(1'b0, 1'b0, 32'h77, 32'h33, 1'b1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy8, done8, cout8, s8} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_mid_run: got %b right after reset, want all zero", {busy8, done8, cout8, s8});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(negedge clk);
      if (done8 || busy8) dones++;
    end
    vectors++;
    if (dones !== 0) begin
      miscompares++;
      $display("FAIL reset_abort: got %0d busy/done cycles after abort, want 0", dones);
    end
    do_op(1'b0, 32'h0F, 32'h01, 1'b0, 1'b0, res, busy_n, lat, both);
    vectors++;
    if (res !== 33'h010) begin
      miscompares++;
      $display("FAIL reset_fresh_op: got %h, want 010", res);
    end
  endtask

  // Random operands, random start/operand noise while running, random idle gaps.
  task automatic test_random(input bit w16);
    logic [31:0] av, bv;
    logic        cv;
    logic [32:0] res, exp;
    int busy_n, lat;
    bit both;
    int w;
    w = w16 ? 16 : 8;
    for (int n = 0; n < 1000; n++) begin
      av = $urandom; bv = $urandom; cv = 1'($urandom_range(0, 1));
      exp = ref_sum(w16, av, bv, cv);
      do_op(w16, av, bv, cv, 1'b1, res, busy_n, lat, both);
      vectors++;
      if (res !== exp) begin
        miscompares++;
        $display("FAIL random_sum w=%0d op=%0d: got %h, want %h", w, n, res, exp);
      end
      vectors++;
      if (lat !== w + 1 || busy_n !== w || both !== 1'b0) begin
        miscompares++;
        $display("FAIL random_timing w=%0d op=%0d: got lat=%0d busy=%0d both=%0d, want lat=%0d busy=%0d both=0",
                 w, n, lat, busy_n, both, w + 1, w);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_operand_change();
    test_reset_mid_run();
    test_random(1'b0);
    test_random(1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
